// File: rtl/uart_rx_fsm_pkg.sv
// Shared definitions for the UART receive controller: state encodings, frame width
// and the legal oversampling ratios.
package uart_rx_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int         DATA_W        = 8;
  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_W);

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and bit counter for the UART receiver; counts only while
// enabled and is cleared synchronously when the frame ends or aborts.
module UART_RX_edge_bit_counter
  import uart_rx_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       clr,
  input  logic [5:0] Prescale,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       end_of_bit
);

  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [3:0] bit_cnt_q,  bit_cnt_d;

  // Prescale-1 stays at 6 bits so Prescale=32 compares against edge index 31.
  assign end_of_bit = ({1'b0, edge_cnt_q} == (Prescale - 6'd1));

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!en || clr) begin
      edge_cnt_d = 5'd0;
      bit_cnt_d  = 4'd0;
    end else if (end_of_bit) begin
      edge_cnt_d = 5'd0;
      bit_cnt_d  = bit_cnt_q + 4'd1;
    end else begin
      edge_cnt_d = edge_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= 5'd0;
      bit_cnt_q  <= 4'd0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller. Define UART_RX_PARITY_EN to build the PARITY state;
// otherwise PAR_EN and par_err are ignored and DATA always proceeds to STOP.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [4:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid
);

  state_t state_q, state_d;
  logic   data_valid_q, data_valid_d;
  logic   end_of_bit;
  logic   cnt_clr;

  UART_RX_edge_bit_counter u_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .en         (state_q != IDLE),
    .clr        (cnt_clr),
    .Prescale   (Prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .end_of_bit (end_of_bit)
  );

  always_comb begin
    state_d      = state_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE:   if (!RX_IN) state_d = START;
      START:  if (end_of_bit) state_d = strt_glitch ? IDLE : DATA;
      DATA: begin
        if (end_of_bit && (bit_cnt == LAST_DATA_BIT)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PAR_EN ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (end_of_bit) state_d = par_err ? IDLE : STOP;
`endif
      STOP: begin
        if (end_of_bit) begin
          state_d      = IDLE;
          data_valid_d = !stp_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clearing on the returning edge keeps the counters at zero for the whole IDLE stay.
  assign cnt_clr = end_of_bit && (state_d == IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign dat_samp_en = (state_q != IDLE);
  assign strt_chk_en = (state_q == START);
  assign stp_chk_en  = (state_q == STOP);
  // Two edges past mid-bit so the sampler's majority result has settled.
  assign deser_en    = (state_q == DATA) &&
                       ({1'b0, edge_cnt} == ((Prescale >> 1) + 6'd2));
  assign data_valid  = data_valid_q;

`ifdef UART_RX_PARITY_EN
  assign par_chk_en = (state_q == PARITY);
`else
  logic unused_parity_inputs;
  assign unused_parity_inputs = PAR_EN | par_err;
  assign par_chk_en           = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frames are driven step by step, deser_en/data_valid
// events are predicted into a queue and checked by a negedge monitor.
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif
  localparam int DV_CODE = 999;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  uart_rx_fsm dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .Prescale    (Prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, dut.state_q, 0);
    chk({tag, "_edge"}, edge_cnt, 0);
    chk({tag, "_bit"}, bit_cnt, 0);
  endtask

  // Scoreboard side: every observed strobe must match the oldest predicted event.
  always @(negedge CLK) begin
    if (deser_en) begin
      chk("deser_predicted", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("deser_position", 100 * bit_cnt + edge_cnt, exp_q.pop_front());
    end
    if (data_valid) begin
      chk("dv_predicted", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("dv_event", DV_CODE, exp_q.pop_front());
    end
  end

  task automatic run_frame(input int p, input logic [7:0] data, input logic pe,
                           input logic glitch, input logic perr, input logic serr,
                           input int rst_bit);
    bit to_par;
    Prescale = 6'(p);
    PAR_EN   = pe;
    RX_IN    = 1'b0;
    tick();
    chk("start_state", dut.state_q, 1);
    chk("start_edge", edge_cnt, 0);
    chk("start_bit", bit_cnt, 0);
    chk("strt_chk_en", strt_chk_en, 1);
    for (int e = 0; e < p; e++) begin
      if (glitch && e == 3) RX_IN = 1'b1;
      strt_glitch = glitch && (e == p - 1);
      tick();
    end
    strt_glitch = 1'b0;
    if (glitch) begin
      chk_idle("glitch");
      chk("glitch_dv", data_valid, 0);
      return;
    end

    for (int b = 1; b <= 8; b++) begin
      chk("data_state", dut.state_q, 2);
      chk("data_bit", bit_cnt, b);
      chk("data_edge", edge_cnt, 0);
      if (b != rst_bit) exp_q.push_back(100 * b + p / 2 + 2);
      for (int e = 0; e < p; e++) begin
        RX_IN  = data[b-1];
        PAR_EN = (b == 8 && e == p - 1) ? pe : ~pe;
        if (b == rst_bit && e == 2) begin
          #2 RST = 1'b0;
          #1;
          chk_idle("async_rst");
          chk("async_rst_dv", data_valid, 0);
          chk("async_rst_deser", deser_en, 0);
          chk("async_rst_samp", dat_samp_en, 0);
          RX_IN = 1'b1;
          PAR_EN = pe;
          tick();
          RST = 1'b1;
          repeat (3) tick();
          chk("post_rst_idle", dut.state_q, 0);
          return;
        end
        tick();
      end
    end
    PAR_EN = pe;

    to_par = PAR_BUILT && pe;
    chk("after_data_state", dut.state_q, to_par ? 3 : 4);
    chk("after_data_bit", bit_cnt, 9);
    if (to_par) begin
      chk("par_chk_en_on", par_chk_en, 1);
      for (int e = 0; e < p; e++) begin
        RX_IN   = ^data;
        par_err = perr && (e == p - 1);
        tick();
      end
      par_err = 1'b0;
      if (perr) begin
        chk_idle("par_abort");
        chk("par_abort_dv", data_valid, 0);
        RX_IN = 1'b1;
        return;
      end
      chk("after_par_state", dut.state_q, 4);
    end else begin
      chk("par_chk_en_off", par_chk_en, 0);
    end

    chk("stp_chk_en", stp_chk_en, 1);
    if (!serr) exp_q.push_back(DV_CODE);
    for (int e = 0; e < p; e++) begin
      RX_IN   = 1'b1;
      stp_err = serr && (e == p - 1);
      tick();
    end
    stp_err = 1'b0;
    chk_idle("frame_end");
    chk("frame_end_dv", data_valid, !serr);
    tick();
    chk("dv_one_cycle", data_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk_idle("reset");
    chk("reset_dv", data_valid, 0);
    chk("reset_deser", deser_en, 0);
    chk("reset_samp", dat_samp_en, 0);
    tick();
    RST = 1'b1;
    repeat (4) tick();
    chk("idle_hold_state", dut.state_q, 0);
    chk("idle_hold_edge", edge_cnt, 0);

    run_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_frame(8, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) tick();
    run_frame(32, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_frame(32, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run_frame(8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    run_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(8, 8'hED, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(8, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: UART_RX_FSM

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RST as elsewhere in the UART path.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  synchronised serial line; idle level is 1.
- PAR_EN  in  1  enables the parity bit in the frame.
- Prescale  in  6  oversampling ratio; only 8, 16 and 32 are legal.
- strt_glitch  in  1  registered start-glitch flag from the start checker.
- par_err  in  1  registered parity-error flag.
- stp_err  in  1  registered stop-error flag.
- edge_cnt  out  5  oversample edge index within the current bit.
- bit_cnt  out  4  bit index within the frame; start bit is 0.
- dat_samp_en  out  1  enables the data sampler.
- strt_chk_en  out  1  enables the start checker.
- par_chk_en  out  1  enables the parity checker.
- stp_chk_en  out  1  enables the stop checker.
- deser_en  out  1  one-cycle shift strobe to the deserialiser.
- data_valid  out  1  one-cycle pulse: frame accepted.

Function
REQ-003 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, held in a 3-bit register.
REQ-004 IDLE transitions:
- RX_IN==0 sampled in IDLE -> START.
- Otherwise stay in IDLE.
REQ-005 The counters SHALL run only when the state is not IDLE; in IDLE, edge_cnt and bit_cnt SHALL be held at 0.
REQ-006 Counter stepping:
- edge_cnt increments by 1 every cycle.
- At edge_cnt==Prescale-1, edge_cnt wraps to 0 and bit_cnt increments by 1.
- Prescale-1 SHALL be computed at 6-bit width and compared against the zero-extended edge_cnt.
REQ-007 Define "end-of-bit" as edge_cnt==Prescale-1; all state transitions out of START, DATA, PARITY and STOP SHALL occur only on end-of-bit.
REQ-008 START at end-of-bit:
- strt_glitch==1 -> IDLE, counters cleared.
- Otherwise -> DATA.
REQ-009 DATA at end-of-bit with bit_cnt==8:
- PARITY if PAR_EN==1.
- Otherwise STOP.
- For bit_cnt<8, stay in DATA.
REQ-010 PARITY at end-of-bit:
- par_err==1 -> IDLE, no data_valid.
- Otherwise -> STOP.
REQ-011 STOP at end-of-bit:
- stp_err==1 -> IDLE, no data_valid.
- Otherwise -> IDLE with data_valid=1 on the next cycle only.
REQ-012 Enable decoding (combinational Moore):
- dat_samp_en=1 in every state except IDLE.
- strt_chk_en=1 in START.
- par_chk_en=1 in PARITY.
- stp_chk_en=1 in STOP.
REQ-013 deser_en SHALL be 1 for exactly one cycle per data bit: in DATA, when edge_cnt==(Prescale>>1)+2, which allows for sampler latency.
REQ-014 data_valid SHALL be registered, and exactly one pulse SHALL be produced per accepted frame.
REQ-015 PAR_EN SHALL be sampled only at the DATA end-of-bit decision; a change mid-frame SHALL NOT affect the current frame's earlier bits.
REQ-016 A falling edge on RX_IN outside IDLE SHALL NOT restart the frame.

Reset
REQ-017 Asserting RST SHALL asynchronously force the following, including mid-frame: state=IDLE, edge_cnt=0, bit_cnt=0, data_valid=0.
REQ-018 On RST deassertion, the first frame SHALL be accepted only after RX_IN==0 is seen in IDLE.

Configuration
REQ-019 With macro UART_RX_PARITY_EN defined, PARITY and PAR_EN SHALL behave as in REQ-009 and REQ-010.
REQ-020 Without UART_RX_PARITY_EN:
- The PARITY state SHALL NOT be built.
- PAR_EN SHALL be ignored.
- par_chk_en SHALL be tied to 0.
- DATA SHALL always go to STOP.
- The port list SHALL be unchanged.

Structure
REQ-021 A shared package SHALL hold the state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), the data width of 8, and the legal Prescale constants.
REQ-022 The edge/bit counters SHALL be a sub-module, UART_RX_edge_bit_counter, with an enable input and the CLK/RST ports.
- Its enable is high when state!=IDLE.
- The FSM top SHALL instantiate it.

Verification
REQ-023 Prescale=8, PAR_EN=0, frame 0xA5 with a good stop bit:
- deser_en pulses at edge_cnt=6 for bits 1..8.
- data_valid is pulsed once, at the cycle after the stop end-of-bit.
REQ-024 Prescale=16, PAR_EN=1, 0x3C with even parity and no errors:
- The state sequence IDLE-START-DATA-PARITY-STOP-IDLE is observed.
- One data_valid pulse is produced.
REQ-025 Prescale=8, RX_IN low for 3 cycles, then strt_glitch=1 at edge_cnt=7:
- The FSM returns to IDLE.
- Counters are 0.
- No deser_en and no data_valid.
REQ-026 Prescale=32, par_err=1 at the PARITY end-of-bit:
- The FSM goes to IDLE with no data_valid.
- A stp_err=1 case on the next frame likewise gives no data_valid.
REQ-027 Prescale=8, RST asserted at DATA with bit_cnt=4:
- Everything is 0 and the state is IDLE immediately.
- Two back-to-back frames after release each give one data_valid.
REQ-028 Build without UART_RX_PARITY_EN, PAR_EN=1:
- The frame goes DATA->STOP.
- par_chk_en stays 0.
- data_valid is asserted.
